// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (fixed-priority arbitration).
package ram_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

    // Upper bound on requesters; sizes the id field and the one-hot helper.
    localparam int unsigned MAX_REQ      = 16;
    localparam int unsigned MAX_ID_WIDTH = 4;

    // One-stage response pipeline: who was granted last cycle, if anyone.
    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
    } rsp_pipe_t;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_ID_WIDTH-1:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr_i, wrapping.
// With RAM_ARB_FIXED_PRIO_EN defined the search always starts at index 0
// and ptr_i is ignored.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    // Walk the requesters in priority order and latch onto the first valid one.
    always_comb begin
        int unsigned j;
        logic [IDW-1:0] jj;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int unsigned k = 0; k < N; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (32'(ptr_i) + k) % N;
`endif
            jj = IDW'(j);
            if (!found && req_i[jj]) begin
                found       = 1'b1;
                idx_o       = jj;
                grant_o[jj] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one block-RAM port among NUM_REQ requesters (NUM_REQ in 2..16).
// Round-robin grant, combinational RAM drive, one-cycle response routing.
// Build macro RAM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no pointer register); higher indices may starve in that build.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                pick_any;
    logic [ID_WIDTH-1:0] ptr_q;
    logic                grant_any;
    rsp_pipe_t           rsp_q, rsp_d;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [ID_WIDTH-1:0] ptr_d;

    // Next search start is one past the winner; hold when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (pick_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_WIDTH)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Reset suppresses every grant, so no transfer or RAM write can happen under rst.
    assign grant_any = pick_any & ~rst;
    assign req_ready = rst ? '0 : pick_grant;

    // Mux the winner onto the RAM port; index 0 is presented when idle.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (!rst) begin
            ram_we   = grant_any & req_we[pick_idx];
            ram_addr = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ram_din  = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Capture who was granted so the registered RAM output can be routed back.
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = grant_any;
        rsp_d.id    = MAX_ID_WIDTH'(pick_idx);
    end

    // Response stage register; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) rsp_q <= '0;
        else     rsp_q <= rsp_d;
    end

    assign rsp_valid = rsp_q.valid ? NUM_REQ'(idx_to_onehot(rsp_q.id)) : '0;
    assign rsp_data  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a write-first RAM model.
// Expected responses are queued at grant time and checked one cycle later.
module tb_ram_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     rsp_data, ram_din, ram_dout;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    logic [31:0] ram_mem [0:1023];
    logic [31:0] exp_mem [0:1023];

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE0000 + 32'(a * 3);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first registered RAM port.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_we ? ram_din : ram_mem[ram_addr];
    end

    // Response scoreboard: each negedge either matches the queued entry or expects silence.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [NR-1:0] ev;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e  = sb.pop_front();
                ev = NR'(1) << e.id;
                total++;
                if (rsp_valid !== ev || rsp_data !== e.data) begin
                    bad++;
                    $display("FAIL rsp cyc=%0d: rsp_valid=%b rsp_data=%h, required %b %h",
                             cyc, rsp_valid, rsp_data, ev, e.data);
                end
            end else begin
                total++;
                if (rsp_valid !== '0) begin
                    bad++;
                    $display("FAIL rsp_idle cyc=%0d: rsp_valid=%b, required 0", cyc, rsp_valid);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Queue the response the granted request must produce next cycle.
    task automatic push_expect(input int w);
        exp_t        e;
        logic [AW-1:0] a;
        a      = req_addr[w*AW +: AW];
        e.cyc  = cyc + 1;
        e.id   = w;
        if (req_we[w]) begin
            e.data     = req_wdata[w*DW +: DW];
            exp_mem[a] = e.data;
        end else begin
            e.data = exp_mem[a];
        end
        sb.push_back(e);
    endtask

    task automatic do_reset();
        clear_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(i + 1), 32'hFFFF0000 + 32'(i));
        repeat (2) begin
            @(negedge clk);
            total++;
            if (req_ready !== '0 || ram_we !== 1'b0) begin
                bad++;
                $display("FAIL reset_grant: req_ready=%b ram_we=%b, required 0 0", req_ready, ram_we);
            end
            total++;
            if (ram_addr !== '0 || ram_din !== '0) begin
                bad++;
                $display("FAIL reset_ram: ram_addr=%h ram_din=%h, required 0 0", ram_addr, ram_din);
            end
            tick();
        end
        rst = 1'b0;
        clear_req();
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (req_ready !== '0 || ram_we !== 1'b0) begin
                bad++;
                $display("FAIL idle: req_ready=%b ram_we=%b, required 0 0", req_ready, ram_we);
            end
            tick();
        end
    endtask

    task automatic test_single_write_read();
        logic [AW-1:0] adrs [4];
        bit            wes  [4];
        adrs = '{10'h005, 10'h005, 10'h005, 10'h007};
        wes  = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            set_req(2, 1'b1, wes[k], adrs[k], 32'hDEADBEEF);
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0100 || ram_we !== wes[k] || ram_addr !== adrs[k]) begin
                bad++;
                $display("FAIL single_grant k=%0d: req_ready=%b ram_we=%b ram_addr=%h, required 0100 %b %h",
                         k, req_ready, ram_we, ram_addr, wes[k], adrs[k]);
            end
            if (wes[k]) begin
                total++;
                if (ram_din !== 32'hDEADBEEF) begin
                    bad++;
                    $display("FAIL single_din: ram_din=%h, required deadbeef", ram_din);
                end
            end
            push_expect(2);
            tick();
        end
        clear_req();
        tick();
    endtask

    task automatic test_round_robin();
        int            w;
        logic [NR-1:0] ev;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(10'h100 + i), '0);
        for (int k = 0; k < 8; k++) begin
            w  = k % NR;
            ev = NR'(1) << w;
            @(negedge clk);
            total++;
            if (req_ready !== ev || ram_addr !== AW'(10'h100 + w)) begin
                bad++;
                $display("FAIL rr_order k=%0d: req_ready=%b ram_addr=%h, required %b %h",
                         k, req_ready, ram_addr, ev, AW'(10'h100 + w));
            end
            push_expect(w);
            tick();
        end
        clear_req();
        tick();
    endtask

    task automatic test_wrap_skip();
        set_req(2, 1'b1, 1'b0, 10'h020, '0);
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL wrap_setup: req_ready=%b, required 0100", req_ready);
        end
        push_expect(2);
        tick();
        clear_req();
        set_req(1, 1'b1, 1'b0, 10'h011, '0);
        set_req(3, 1'b1, 1'b0, 10'h033, '0);
        @(negedge clk);
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_first: req_ready=%b, required 1000", req_ready);
        end
        push_expect(3);
        tick();
        set_req(3, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL wrap_skip: req_ready=%b, required 0010", req_ready);
        end
        push_expect(1);
        tick();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(10'h040 + i), '0);
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL wrap_ptr2: req_ready=%b, required 0100", req_ready);
        end
        push_expect(2);
        tick();
        clear_req();
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 1'b0, 10'h015, '0);
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL mid_pre: req_ready=%b, required 0010", req_ready);
        end
        push_expect(1);
        tick();
        rst = 1'b1;
        set_req(1, 1'b1, 1'b1, 10'h3F0, 32'h12345678);
        @(negedge clk);
        total++;
        if (req_ready !== '0 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst: req_ready=%b ram_we=%b, required 0 0", req_ready, ram_we);
        end
        tick();
        rst = 1'b0;
        clear_req();
        set_req(0, 1'b1, 1'b0, 10'h3F0, '0);
        set_req(3, 1'b1, 1'b0, 10'h030, '0);
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_after: req_ready=%b, required 0001", req_ready);
        end
        push_expect(0);
        tick();
        clear_req();
        tick();
    endtask

    task automatic test_pair_priority();
        int exp_w [4];
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_w = '{0, 0, 0, 0};
`else
        exp_w = '{0, 3, 0, 3};
`endif
        do_reset();
        set_req(0, 1'b1, 1'b0, 10'h050, '0);
        set_req(3, 1'b1, 1'b0, 10'h053, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (req_ready !== NR'(NR'(1) << exp_w[k])) begin
                bad++;
                $display("FAIL pair k=%0d: req_ready=%b, required winner %0d", k, req_ready, exp_w[k]);
            end
            push_expect(exp_w[k]);
            tick();
        end
        clear_req();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 1024; a++) begin
            ram_mem[a] = pat(a);
            exp_mem[a] = pat(a);
        end
        ram_dout = '0;
        clear_req();
        test_reset();
        test_single_write_read();
        test_round_robin();
        test_wrap_skip();
        test_reset_mid();
        test_pair_priority();
        repeat (2) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: pending=%0d, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the team's true dual-port block RAM among NUM_REQ requesters, for example bcrypt S-box lookup lanes.
- Arbitrates with round-robin, presents the winning request to the RAM port and routes the registered read data back to the requester that issued it.
- Sits between the cracking cores and the port-A (or port-B) pins of the RAM.
- Sustains one access per cycle with no bubbles.

Parameters:
- NUM_REQ, 4: number of requesters; must be 2..16.
- DATA_WIDTH, 32: RAM word width.
- ADDR_WIDTH, 10: RAM address width.
- ID_WIDTH, $clog2(NUM_REQ): width of the grant index. Derived; do not override.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both 1.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-hot; pulses one cycle after the grant.
- rsp_data  out  DATA_WIDTH  shared response bus; valid only while rsp_valid is nonzero.
- ram_we  out  1  to RAM write enable.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_din  out  DATA_WIDTH  to RAM write data.
- ram_dout  in  DATA_WIDTH  from RAM registered output (write-first port).

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0, ram_we = 0.
  - ram_addr = 0, ram_din = 0.
  - Round-robin pointer = 0.
- Grant (combinational from req_valid and the pointer):
  - Search starts at index ptr and wraps modulo NUM_REQ; the first requester with req_valid set wins.
  - req_ready is one-hot for the winner; all zeros if no requester is valid.
  - req_ready never asserts for a requester whose req_valid is 0.
  - req_ready is forced to 0 while rst = 1.
- RAM drive:
  - ram_we, ram_addr and ram_din are combinationally muxed from the winner.
  - With no grant, ram_we = 0 and ram_addr/ram_din hold the muxed value for index 0 (don't-care, not X).
- Pointer update: on any grant to winner w, ptr <= (w+1) mod NUM_REQ. With no grant, ptr holds.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Response pipeline:
  - A one-stage register stores the grant index and a valid bit.
  - Next cycle, rsp_valid[id] = 1 and rsp_data = ram_dout.
  - Reads return mem[addr]; writes return the written data (write-first echo), acting as a write ack.
  - Latency is exactly 1 cycle, grant to rsp_valid.
  - Throughput is one transfer per cycle; back-to-back grants to the same requester are allowed if it is the only one valid.
- Requester obligations:
  - Hold req_we, req_addr and req_wdata stable while req_valid = 1 and req_ready = 0.
  - Dropping req_valid before the grant is permitted (withdraw); nothing is issued.
- Simultaneous events: all NUM_REQ valid in the same cycle gives grants in the order ptr, ptr+1, ... across consecutive cycles.
- Wrap-around: ptr = NUM_REQ-1 with winner NUM_REQ-1 gives ptr = 0.
- Reset mid-operation:
  - An in-flight response is discarded; rsp_valid = 0 in the cycle after rst is sampled.
  - ptr returns to 0.
  - No RAM write is issued during any cycle in which rst = 1.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; the lowest index wins.
  - The pointer register is removed.
  - Starvation of higher indices is permitted and documented.
  - Response path is unchanged.
- Undefined (default): round-robin as above.

Decomposition:
- Package ram_arb_pkg:
  - Default widths: DATA_WIDTH 32, ADDR_WIDTH 10, NUM_REQ 4.
  - Function idx_to_onehot.
  - Typedef for the response-pipeline struct: valid plus id.
- Sub-module rr_pick:
  - Combinational rotating priority encoder.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, binary index and any-grant flag.
  - Under RAM_ARB_FIXED_PRIO_EN it reduces to plain priority.
- ram_port_arbiter owns the pointer register, the muxes and the response stage.

Test Plan:
1. Reset then idle, with rst held 2 cycles and all req_valid = 0 → all outputs 0; ram_we never 1; ptr = 0.
2. Single requester 2 writes addr 0x005 data 0xDEADBEEF, then reads 0x005 → rsp_valid[2] is 1 the cycle after each grant; the read returns 0xDEADBEEF; rsp_data on the write echoes 0xDEADBEEF.
3. All four requesters valid continuously for 8 cycles, each reading its own address → grant order 0,1,2,3,0,1,2,3; rsp_valid rotates one cycle later; rsp_data matches preloaded contents.
4. Wrap and skip: ptr = 3, only requesters 1 and 3 valid → grant 3 then 1; ptr ends at 2.
5. Reset mid-operation: rst asserted in the cycle a read to requester 1 is granted → no rsp_valid next cycle; after release, requester 0 wins first.
6. RAM_ARB_FIXED_PRIO_EN defined, requesters 0 and 3 both valid for 4 cycles → requester 0 is granted every cycle; requester 3 gets req_ready = 0 throughout.
